// File: rtl/ether_byte_evt_if.sv
// ether_byte_evt_if -- RMII-style receive dibit stream in, byte/frame events out.
// master: the side that drives the receive stream (e.g. a PHY model).
// slave : the decoder (ether_byte_evt).
interface ether_byte_evt_if;
  logic        crsdv_in;
  logic [1:0]  rxd_in;
  logic        byte_evt_out;
  logic [7:0]  byte_out;
  logic        frame_done_out;
  logic        err_out;
  logic [15:0] frame_len_out;

  modport master (
    output crsdv_in, rxd_in,
    input  byte_evt_out, byte_out, frame_done_out, err_out, frame_len_out
  );

  modport slave (
    input  crsdv_in, rxd_in,
    output byte_evt_out, byte_out, frame_done_out, err_out, frame_len_out
  );
endinterface

// File: rtl/ether_byte_evt.sv
// ether_byte_evt -- decodes a receive dibit stream (preamble 01..01, SFD 11,
// payload LSB-first) into per-byte event pulses and end-of-frame pulses.
// Optional feature macro: FRAME_LEN_EN -- when defined, a saturating payload
// byte counter is kept and reported on frame_len_out; otherwise it reads 0.
module ether_byte_evt #(
  parameter int unsigned MIN_PREAMBLE = 16
) (
  input logic             clk_in,
  input logic             rst_in,
  ether_byte_evt_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [7:0] MIN_PRE = 8'(MIN_PREAMBLE);

  state_t      state, state_nxt;
  logic [7:0]  pre_cnt, pre_cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_byte, data_byte_nxt;
  logic        evt, evt_nxt;
  logic        done, done_nxt;
  logic        err, err_nxt;
  logic        start;

  // Next-state and next-output decode for the receive FSM.
  always_comb begin
    state_nxt     = state;
    pre_cnt_nxt   = pre_cnt;
    idx_nxt       = idx;
    shift_nxt     = shift;
    data_byte_nxt = data_byte;
    evt_nxt       = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    start         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.crsdv_in) begin
          if (bus.rxd_in == 2'b01) begin
            state_nxt   = PREAMBLE;
            pre_cnt_nxt = 8'd1;
          end else begin
            state_nxt = DROP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      PREAMBLE: begin
        if (!bus.crsdv_in) begin
          // Carrier lost before the SFD: silently back to idle.
          state_nxt = IDLE;
        end else begin
          case (bus.rxd_in)
            2'b01: begin
              if (pre_cnt != 8'hFF) begin
                pre_cnt_nxt = pre_cnt + 8'd1;
              end else begin
                pre_cnt_nxt = pre_cnt;
              end
            end
            2'b11: begin
              if (pre_cnt >= MIN_PRE) begin
                state_nxt = DATA;
                idx_nxt   = 2'd0;
                shift_nxt = 8'h00;
                start     = 1'b1;
              end else begin
                state_nxt = DROP;
              end
            end
            default: state_nxt = DROP;
          endcase
        end
      end
      DATA: begin
        if (bus.crsdv_in) begin
          shift_nxt[{idx, 1'b0} +: 2] = bus.rxd_in;
          idx_nxt = idx + 2'd1;
          if (idx == 2'd3) begin
            data_byte_nxt = shift_nxt;
            evt_nxt       = 1'b1;
          end else begin
            data_byte_nxt = data_byte;
          end
        end else begin
          // End of frame; a non-zero index means a partial byte is dropped.
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
          done_nxt  = 1'b1;
          err_nxt   = (idx != 2'd0);
        end
      end
      DROP: begin
        if (!bus.crsdv_in) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DROP;
        end
      end
      default: state_nxt = DROP;
    endcase
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= DROP;
      pre_cnt   <= 8'd0;
      idx       <= 2'd0;
      shift     <= 8'h00;
      data_byte <= 8'h00;
      evt       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      data_byte <= data_byte_nxt;
      evt       <= evt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  assign bus.byte_evt_out   = evt;
  assign bus.byte_out       = data_byte;
  assign bus.frame_done_out = done;
  assign bus.err_out        = err;

`ifdef FRAME_LEN_EN
  logic [15:0] len_cnt, len_cnt_nxt;
  logic [15:0] frame_len, frame_len_nxt;

  // Payload byte counter: cleared at SFD, counts each byte event, saturates.
  always_comb begin
    len_cnt_nxt = len_cnt;
    if (start) begin
      len_cnt_nxt = 16'h0000;
    end else if (evt && (len_cnt != 16'hFFFF)) begin
      len_cnt_nxt = len_cnt + 16'd1;
    end else begin
      len_cnt_nxt = len_cnt;
    end
    // Capture includes a byte event landing on the same edge as frame end.
    if (done_nxt) begin
      frame_len_nxt = len_cnt_nxt;
    end else begin
      frame_len_nxt = frame_len;
    end
  end

  // Byte counter and reported frame length registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      len_cnt   <= 16'h0000;
      frame_len <= 16'h0000;
    end else begin
      len_cnt   <= len_cnt_nxt;
      frame_len <= frame_len_nxt;
    end
  end

  assign bus.frame_len_out = frame_len;
`else
  assign bus.frame_len_out = 16'h0000;
`endif

endmodule

// File: tb/tb_ether_byte_evt.sv
// tb_ether_byte_evt -- directed bench for ether_byte_evt (MIN_PREAMBLE=16).
// Works with or without FRAME_LEN_EN defined.
module tb_ether_byte_evt;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ether_byte_evt_if bus();

  ether_byte_evt #(.MIN_PREAMBLE(16)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

`ifdef FRAME_LEN_EN
  localparam int LEN_ON = 1;
`else
  localparam int LEN_ON = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Event monitor: tallies output pulses mid-cycle.
  int         cyc       = 0;
  int         n_evt     = 0;
  int         n_done    = 0;
  int         n_err     = 0;
  int         n_overlap = 0;
  logic [7:0] evt_bytes[$];
  int         evt_cyc[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.byte_evt_out === 1'b1) begin
      n_evt = n_evt + 1;
      evt_bytes.push_back(bus.byte_out);
      evt_cyc.push_back(cyc);
    end
    if (bus.frame_done_out === 1'b1) n_done = n_done + 1;
    if (bus.err_out === 1'b1) n_err = n_err + 1;
    if ((bus.byte_evt_out === 1'b1) && (bus.frame_done_out === 1'b1)) n_overlap = n_overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One dibit slot: drive inputs, let the DUT sample, settle past the edge.
  task automatic step(input logic c, input logic [1:0] d);
    bus.crsdv_in = c;
    bus.rxd_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pre(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b01);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) step(1'b1, b[2*i +: 2]);
  endtask

  task automatic idle2();
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
  endtask

  int e0, d0, r0, q0;

  task automatic snap();
    e0 = n_evt; d0 = n_done; r0 = n_err; q0 = evt_bytes.size();
  endtask

  initial begin
    bus.crsdv_in = 1'b0;
    bus.rxd_in   = 2'b00;

    // Reset state
    rst = 1'b1;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    chk("rst_evt",  32'(bus.byte_evt_out),   32'd0);
    chk("rst_done", 32'(bus.frame_done_out), 32'd0);
    chk("rst_err",  32'(bus.err_out),        32'd0);
    chk("rst_byte", 32'(bus.byte_out),       32'd0);
    chk("rst_len",  32'(bus.frame_len_out),  32'd0);
    rst = 1'b0;
    idle2();

    // Two-byte frame A5, 3C after a 31-dibit preamble
    snap();
    send_pre(31);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01); step(1'b1, 2'b01); step(1'b1, 2'b10); step(1'b1, 2'b10);
    chk("f1_evt0",  32'(bus.byte_evt_out), 32'd1);
    chk("f1_byte0", 32'(bus.byte_out),     32'hA5);
    step(1'b1, 2'b00);
    chk("f1_evt_low", 32'(bus.byte_evt_out), 32'd0);
    chk("f1_hold",    32'(bus.byte_out),     32'hA5);
    step(1'b1, 2'b11); step(1'b1, 2'b11); step(1'b1, 2'b00);
    chk("f1_evt1",  32'(bus.byte_evt_out), 32'd1);
    chk("f1_byte1", 32'(bus.byte_out),     32'h3C);
    chk("f1_nodone_with_evt", 32'(bus.frame_done_out), 32'd0);
    step(1'b0, 2'b00);
    chk("f1_done",  32'(bus.frame_done_out), 32'd1);
    chk("f1_evt_at_done", 32'(bus.byte_evt_out), 32'd0);
    chk("f1_err",   32'(bus.err_out),        32'd0);
    chk("f1_len",   32'(bus.frame_len_out),  32'(2 * LEN_ON));
    step(1'b0, 2'b00);
    chk("f1_done_1cyc", 32'(bus.frame_done_out), 32'd0);
    chk("f1_nevt",  32'(n_evt - e0),  32'd2);
    chk("f1_q0",    32'(evt_bytes[q0]),     32'hA5);
    chk("f1_q1",    32'(evt_bytes[q0 + 1]), 32'h3C);
    chk("f1_gap",   32'(evt_cyc[q0 + 1] - evt_cyc[q0]), 32'd4);
    chk("f1_ndone", 32'(n_done - d0), 32'd1);
    chk("f1_nerr",  32'(n_err - r0),  32'd0);

    // Short preamble (10, then 15 = MIN-1) is dropped
    snap();
    send_pre(10); step(1'b1, 2'b11); send_byte(8'hFF); idle2();
    send_pre(15); step(1'b1, 2'b11); send_byte(8'h5A); idle2();
    chk("short_nevt",  32'(n_evt - e0),  32'd0);
    chk("short_ndone", 32'(n_done - d0), 32'd0);
    chk("short_nerr",  32'(n_err - r0),  32'd0);

    // Exactly MIN_PREAMBLE is accepted
    snap();
    send_pre(16); step(1'b1, 2'b11); send_byte(8'h5A);
    chk("min_evt",  32'(bus.byte_evt_out), 32'd1);
    chk("min_byte", 32'(bus.byte_out),     32'h5A);
    step(1'b0, 2'b00);
    chk("min_done", 32'(bus.frame_done_out), 32'd1);
    chk("min_len",  32'(bus.frame_len_out),  32'(LEN_ON));
    step(1'b0, 2'b00);
    chk("min_nevt", 32'(n_evt - e0), 32'd1);

    // Partial byte at frame end: one event, then done+err together
    snap();
    send_pre(16); step(1'b1, 2'b11); send_byte(8'h96);
    chk("part_byte", 32'(bus.byte_out), 32'h96);
    step(1'b1, 2'b11); step(1'b1, 2'b11);
    step(1'b0, 2'b00);
    chk("part_done", 32'(bus.frame_done_out), 32'd1);
    chk("part_err",  32'(bus.err_out),        32'd1);
    chk("part_len",  32'(bus.frame_len_out),  32'(LEN_ON));
    step(1'b0, 2'b00);
    chk("part_err_1cyc", 32'(bus.err_out), 32'd0);
    chk("part_nevt", 32'(n_evt - e0), 32'd1);
    chk("part_nerr", 32'(n_err - r0), 32'd1);

    // Reset during the second byte: rest of frame ignored
    send_pre(16); step(1'b1, 2'b11); send_byte(8'h11);
    step(1'b1, 2'b01); step(1'b1, 2'b10);
    rst = 1'b1;
    step(1'b1, 2'b11);
    chk("mrst_evt",  32'(bus.byte_evt_out),   32'd0);
    chk("mrst_done", 32'(bus.frame_done_out), 32'd0);
    chk("mrst_err",  32'(bus.err_out),        32'd0);
    chk("mrst_byte", 32'(bus.byte_out),       32'd0);
    chk("mrst_len",  32'(bus.frame_len_out),  32'd0);
    rst = 1'b0;
    snap();
    send_pre(20); step(1'b1, 2'b11); send_byte(8'hD5); idle2();
    chk("mrst_nevt",  32'(n_evt - e0),  32'd0);
    chk("mrst_ndone", 32'(n_done - d0), 32'd0);
    chk("mrst_nerr",  32'(n_err - r0),  32'd0);
    snap();
    send_pre(20); step(1'b1, 2'b11); send_byte(8'hE7); idle2();
    chk("post_rst_nevt",  32'(n_evt - e0),  32'd1);
    chk("post_rst_byte",  32'(evt_bytes[q0]), 32'hE7);
    chk("post_rst_ndone", 32'(n_done - d0), 32'd1);

    // Preamble broken by 10, and frame opening on a non-01 dibit
    snap();
    send_pre(5); step(1'b1, 2'b10); send_pre(20); step(1'b1, 2'b11); send_byte(8'hFF); idle2();
    step(1'b1, 2'b11); send_pre(20); step(1'b1, 2'b11); send_byte(8'hFF); idle2();
    chk("brk_nevt",  32'(n_evt - e0),  32'd0);
    chk("brk_ndone", 32'(n_done - d0), 32'd0);

    // Long preamble (266) must saturate, not wrap, and still be accepted
    snap();
    send_pre(266); step(1'b1, 2'b11); send_byte(8'h42); idle2();
    chk("sat_nevt",  32'(n_evt - e0),  32'd1);
    chk("sat_byte",  32'(evt_bytes[q0]), 32'h42);
    chk("sat_ndone", 32'(n_done - d0), 32'd1);
    chk("sat_nerr",  32'(n_err - r0),  32'd0);

    chk("no_overlap", 32'(n_overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ether_byte_evt.md
ETHER_BYTE_EVT -- requirements
Module: ether_byte_evt

Interface
REQ-001 Parameter MIN_PREAMBLE, default 16: minimum count of consecutive 2'b01 preamble dibits required before the SFD dibit 2'b11.
REQ-002 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 crsdv_in  input  1  receive valid; when high, rxd_in carries one dibit that cycle.
REQ-005 rxd_in  input  2  receive dibit, LSB-first within each byte.
REQ-006 byte_evt_out  output  1  one-cycle pulse per completed payload byte; drives a downstream event counter's evt_in.
REQ-007 byte_out  output  8  assembled byte, valid only while byte_evt_out is high.
REQ-008 frame_done_out  output  1  one-cycle pulse at the end of an accepted frame.
REQ-009 err_out  output  1  one-cycle pulse on a frame that ends with a partial byte.
REQ-010 frame_len_out  output  16  payload byte count of the last completed frame.

Function
REQ-011 States SHALL be IDLE, PREAMBLE, DATA and DROP.
REQ-012 IDLE: crsdv_in=1 with rxd_in=01 -> PREAMBLE, preamble count=1; crsdv_in=1 with any other dibit -> DROP.
REQ-013 PREAMBLE: rxd_in=01 increments the preamble count, saturating at 255.
REQ-014 PREAMBLE: rxd_in=11 with count >= MIN_PREAMBLE -> DATA, dibit index=0, byte count=0; with count < MIN_PREAMBLE -> DROP.
REQ-015 PREAMBLE: rxd_in=00 or 10 -> DROP; crsdv_in=0 -> IDLE with no output pulse.
REQ-016 DATA: each crsdv_in=1 cycle SHALL load the dibit into shift bits [2i+1:2i], where i is the dibit index 0..3, then increment i modulo 4.
REQ-017 On the dibit with i=3, byte_out SHALL present the full byte and byte_evt_out SHALL pulse high on the next cycle (latency 1 cycle).
REQ-018 DATA: crsdv_in=0 with i=0 -> IDLE, and frame_done_out SHALL pulse on the next cycle.
REQ-019 DATA: crsdv_in=0 with i!=0 -> IDLE, the partial byte SHALL be discarded with no byte_evt_out, and frame_done_out and err_out SHALL both pulse on the next cycle.
REQ-020 DROP: all input SHALL be ignored, with no output pulses; crsdv_in=0 -> IDLE.
REQ-021 byte_evt_out and frame_done_out SHALL never be high in the same cycle; a byte completed on the last valid dibit gives byte_evt_out at k+1 and frame_done_out at k+2.
REQ-022 byte_out SHALL hold its last value when byte_evt_out is low.
REQ-023 A frame of back-to-back bytes SHALL produce byte_evt_out pulses exactly 4 cycles apart.

Reset
REQ-024 rst_in=1 SHALL force state to DROP, so that a frame in progress is ignored until crsdv_in goes low.
REQ-025 rst_in=1 SHALL clear byte_evt_out, frame_done_out and err_out to 0.
REQ-026 rst_in=1 SHALL clear byte_out, frame_len_out, all counters and the shift register to 0.
REQ-027 Reset SHALL override every other input in the same cycle, including mid-byte and mid-preamble.

Configuration
REQ-028 With macro FRAME_LEN_EN defined, a 16-bit byte counter SHALL increment on each byte_evt_out and saturate at 16'hFFFF.
REQ-029 With FRAME_LEN_EN defined, the counter value SHALL be copied into frame_len_out in the cycle frame_done_out is high, and the counter cleared on entry to DATA.
REQ-030 Without FRAME_LEN_EN, the counter logic SHALL be absent and frame_len_out SHALL be constant 0.

Verification
REQ-031 31x dibit 01, then 11, then dibits of bytes 0xA5, 0x3C (01,01,10,10, 00,11,11,00), then crsdv_in low -> byte_out 0xA5 then 0x3C, pulses 4 cycles apart; one frame_done_out; err_out=0; frame_len_out=2 with FRAME_LEN_EN.
REQ-032 10x 01, then 11, with MIN_PREAMBLE=16 -> DROP; no pulses until crsdv_in low; the following valid frame is accepted.
REQ-033 Valid preamble and SFD, 6 data dibits, then crsdv_in low -> one byte_evt_out, then frame_done_out and err_out high together one cycle.
REQ-034 rst_in high for 1 cycle during the second byte of a frame -> all outputs 0; no pulses for the rest of that frame; the next frame is decoded normally.
REQ-035 Preamble interrupted by dibit 10 -> DROP, no pulses; crsdv_in low then a valid frame -> decoded correctly.
REQ-036 Build without FRAME_LEN_EN and run REQ-031 stimulus -> identical pulses and bytes; frame_len_out stays 0.
